// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation controller.
//   MAX_BIT / MAX_BIT_BIT : default operand width and exponent bit-index width
//   state_e               : sequencer FSM states
//   opsel_e               : which operand pair the next multiplier job uses
package rsa_pkg;

    localparam int MAX_BIT     = 2048;
    localparam int MAX_BIT_BIT = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOMONT_M,
        S_TOMONT_1,
        S_SQUARE,
        S_MULT,
        S_NEXT,
        S_FROMMONT,
        S_FINISH
    } state_e;

    // Operand pairs (X, Y) fed to the Montgomery multiplier.
    typedef enum logic [2:0] {
        M_R2,    // (M, R2)       -> Mbar
        ONE_R2,  // (1, R2)       -> R mod N
        SQR,     // (Abar, Abar)
        MUL,     // (Abar, Mbar)
        FROM     // (Abar, 1)     -> leave Montgomery domain
    } opsel_e;

endpackage

// File: rtl/rsa_modexp_ctrl_if.sv
// START/DONE job interface between the exponentiation controller and a
// Montgomery multiplier.
//   master : controller side (drives MM_START, MM_X, MM_Y, MM_N)
//   slave  : multiplier side (drives MM_O, MM_DONE)
// MM_O is valid only in the MM_DONE cycle.
interface rsa_modexp_ctrl_if
    import rsa_pkg::*;
#(
    parameter int MAX_BIT = rsa_pkg::MAX_BIT
);

    logic               MM_START;
    logic [MAX_BIT-1:0] MM_X;
    logic [MAX_BIT-1:0] MM_Y;
    logic [MAX_BIT-1:0] MM_N;
    logic [MAX_BIT-1:0] MM_O;
    logic               MM_DONE;

    modport master (output MM_START, MM_X, MM_Y, MM_N, input MM_O, MM_DONE);
    modport slave  (input MM_START, MM_X, MM_Y, MM_N, output MM_O, MM_DONE);

endinterface

// File: rtl/rsa_modexp_ctrl_mm_job_port.sv
// Single-outstanding-job port towards the Montgomery multiplier.
//   clk, rst           : clock, synchronous active-high reset
//   start_job          : request a job with operands job_x/job_y/job_n
//   job_done           : one-cycle pulse, job_result valid in the same cycle
//   mm                 : multiplier interface (master side)
// Operands are registered on issue and held until the next issue, so they
// stay stable while the multiplier reads Y and N live and through the cycle
// after MM_DONE. MM_DONE with no job pending is ignored.
module mm_job_port
    import rsa_pkg::*;
#(
    parameter int MAX_BIT = rsa_pkg::MAX_BIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_job,
    input  logic [MAX_BIT-1:0] job_x,
    input  logic [MAX_BIT-1:0] job_y,
    input  logic [MAX_BIT-1:0] job_n,
    output logic               job_done,
    output logic [MAX_BIT-1:0] job_result,
    rsa_modexp_ctrl_if.master  mm
);

    logic [MAX_BIT-1:0] x_q, x_d, y_q, y_d, n_q, n_d, result_q, result_d;
    logic               start_q, start_d, pending_q, pending_d, done_q, done_d;

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        n_d       = n_q;
        result_d  = result_q;
        start_d   = 1'b0;
        done_d    = 1'b0;
        pending_d = pending_q;
        if (pending_q && mm.MM_DONE) begin
            pending_d = 1'b0;
            done_d    = 1'b1;
            result_d  = mm.MM_O;
        end
        if (start_job && !pending_q) begin
            x_d       = job_x;
            y_d       = job_y;
            n_d       = job_n;
            start_d   = 1'b1;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            n_q       <= '0;
            result_q  <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            n_q       <= n_d;
            result_q  <= result_d;
            start_q   <= start_d;
            done_q    <= done_d;
            pending_q <= pending_d;
        end
    end

    assign mm.MM_START = start_q;
    assign mm.MM_X     = x_q;
    assign mm.MM_Y     = y_q;
    assign mm.MM_N     = n_q;
    assign job_done    = done_q;
    assign job_result  = result_q;

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// O = M^E mod N by left-to-right square-and-multiply in the Montgomery domain.
//   clk, rst                 : clock, synchronous active-high reset
//   START, M, E, N, R2       : host request; operands latched when accepted in IDLE
//   O, DONE, BUSY            : result (held until next accepted START), done pulse, busy
//   mm                       : Montgomery multiplier job interface (master side)
// Every exponent bit is processed (no leading-zero skip), so the job count is
// MAX_BIT + popcount(E) + 3.
module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int MAX_BIT     = rsa_pkg::MAX_BIT,
    parameter int MAX_BIT_BIT = rsa_pkg::MAX_BIT_BIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               START,
    input  logic [MAX_BIT-1:0] M,
    input  logic [MAX_BIT-1:0] E,
    input  logic [MAX_BIT-1:0] N,
    input  logic [MAX_BIT-1:0] R2,
    output logic [MAX_BIT-1:0] O,
    output logic               DONE,
    output logic               BUSY,
    rsa_modexp_ctrl_if.master  mm
);

    localparam logic [MAX_BIT-1:0]     ONE     = {{(MAX_BIT-1){1'b0}}, 1'b1};
    localparam logic [MAX_BIT_BIT-1:0] IDX_MSB = MAX_BIT_BIT'(MAX_BIT - 1);

    state_e                 state_q;
    opsel_e                 sel_q;
    logic [MAX_BIT-1:0]     m_q, e_q, n_q, r2_q, mbar_q, abar_q, o_q;
    logic [MAX_BIT_BIT-1:0] idx_q;
    logic                   done_q, busy_q, start_job_q;

    logic [MAX_BIT-1:0]     job_x, job_y, job_result;
    logic                   job_done;

    // Operand pair for the job being issued; sel_q and the source registers
    // are both settled by the time start_job_q is high.
    always_comb begin
        job_x = abar_q;
        job_y = abar_q;
        case (sel_q)
            M_R2:    begin job_x = m_q; job_y = r2_q; end
            ONE_R2:  begin job_x = ONE; job_y = r2_q; end
            SQR:     ;
            MUL:     job_y = mbar_q;
            FROM:    job_y = ONE;
            default: ;
        endcase
    end

    mm_job_port #(.MAX_BIT(MAX_BIT)) u_job (
        .clk        (clk),
        .rst        (rst),
        .start_job  (start_job_q),
        .job_x      (job_x),
        .job_y      (job_y),
        .job_n      (n_q),
        .job_done   (job_done),
        .job_result (job_result),
        .mm         (mm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= M_R2;
            m_q         <= '0;
            e_q         <= '0;
            n_q         <= '0;
            r2_q        <= '0;
            mbar_q      <= '0;
            abar_q      <= '0;
            o_q         <= '0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            start_job_q <= 1'b0;
        end else begin
            start_job_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: if (START) begin
                    m_q         <= M;
                    e_q         <= E;
                    n_q         <= N;
                    r2_q        <= R2;
                    busy_q      <= 1'b1;
                    sel_q       <= M_R2;
                    start_job_q <= 1'b1;
                    state_q     <= S_TOMONT_M;
                end
                S_TOMONT_M: if (job_done) begin
                    mbar_q      <= job_result;
                    sel_q       <= ONE_R2;
                    start_job_q <= 1'b1;
                    state_q     <= S_TOMONT_1;
                end
                S_TOMONT_1: if (job_done) begin
                    abar_q      <= job_result;   // R mod N, i.e. Montgomery 1
                    idx_q       <= IDX_MSB;
                    sel_q       <= SQR;
                    start_job_q <= 1'b1;
                    state_q     <= S_SQUARE;
                end
                S_SQUARE: if (job_done) begin
                    abar_q <= job_result;
                    if (e_q[idx_q]) begin
                        sel_q       <= MUL;
                        start_job_q <= 1'b1;
                        state_q     <= S_MULT;
                    end else begin
                        state_q     <= S_NEXT;
                    end
                end
                S_MULT: if (job_done) begin
                    abar_q  <= job_result;
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    start_job_q <= 1'b1;
                    if (idx_q == '0) begin
                        sel_q   <= FROM;
                        state_q <= S_FROMMONT;
                    end else begin
                        idx_q   <= idx_q - 1'b1;
                        sel_q   <= SQR;
                        state_q <= S_SQUARE;
                    end
                end
                S_FROMMONT: if (job_done) begin
                    o_q     <= job_result;
                    done_q  <= 1'b1;
                    state_q <= S_FINISH;
                end
                S_FINISH: begin
                    // START is not sampled here; it is accepted from the next cycle.
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign O    = o_q;
    assign DONE = done_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Directed bench for rsa_modexp_ctrl with MAX_BIT = 32. A behavioural
// Montgomery multiplier (x*y*R^-1 mod n) answers jobs with fixed or random
// latency and tracks operand stability and job overlap.
module tb_rsa_modexp_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         START;
    logic [W-1:0] M, E, N, R2, O;
    logic         DONE, BUSY;

    rsa_modexp_ctrl_if #(.MAX_BIT(W)) mm_if ();

    rsa_modexp_ctrl #(.MAX_BIT(W), .MAX_BIT_BIT(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .START (START),
        .M     (M),
        .E     (E),
        .N     (N),
        .R2    (R2),
        .O     (O),
        .DONE  (DONE),
        .BUSY  (BUSY),
        .mm    (mm_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // x*y*2^-32 mod n: reduce the product, then halve mod n 32 times.
    function automatic logic [W-1:0] mont(input logic [W-1:0] x, y, n);
        logic [63:0] t, h;
        h = (64'(n) + 64'd1) >> 1;
        t = (64'(x) * 64'(y)) % 64'(n);
        for (int i = 0; i < W; i++) t = (t * h) % 64'(n);
        return t[W-1:0];
    endfunction

    // Multiplier model (acts at posedge+1)
    bit           lat_rand = 1'b0;
    bit           spur     = 1'b0;
    bit           mdl_busy = 1'b0;
    bit           mdl_hold = 1'b0;
    int           mdl_cnt  = 0;
    int           mm_jobs  = 0;
    int           stab_viol = 0;
    logic [W-1:0] lx, ly, ln, mdl_res;

    initial begin
        mm_if.MM_DONE = 1'b0;
        mm_if.MM_O    = '0;
        lx = '0; ly = '0; ln = '0; mdl_res = '0;
        forever begin
            @(posedge clk); #1;
            if (mdl_busy || mdl_hold) begin
                if (mm_if.MM_X !== lx || mm_if.MM_Y !== ly || mm_if.MM_N !== ln) stab_viol++;
            end
            mdl_hold      = 1'b0;
            mm_if.MM_DONE = 1'b0;
            if (mm_if.MM_START) begin
                if (mdl_busy) stab_viol++;
                lx       = mm_if.MM_X;
                ly       = mm_if.MM_Y;
                ln       = mm_if.MM_N;
                mdl_res  = mont(lx, ly, ln);
                mdl_busy = 1'b1;
                mdl_cnt  = lat_rand ? int'($urandom_range(1, 40)) : 3;
                mm_jobs++;
            end else if (mdl_busy) begin
                mdl_cnt--;
                if (mdl_cnt == 0) begin
                    mm_if.MM_DONE = 1'b1;
                    mm_if.MM_O    = mdl_res;
                    mdl_busy      = 1'b0;
                    mdl_hold      = 1'b1;
                end
            end else if (spur) begin
                mm_if.MM_DONE = 1'b1;
                mm_if.MM_O    = 32'd123;
            end
        end
    end

    // Starts at posedge+2 in an IDLE cycle; returns at posedge+2 of the cycle after DONE.
    task automatic run_op(input string tag, input logic [W-1:0] m, e, exp_o,
                          input int exp_jobs, input logic [W-1:0] prev_o, input bit repulse);
        int base_jobs, base_viol;
        bit got;
        base_jobs = mm_jobs;
        base_viol = stab_viol;
        START = 1'b1; M = m; E = e; N = 32'd497; R2 = 32'd436;
        @(posedge clk); #2;
        START = 1'b0; M = $urandom; E = $urandom; N = $urandom; R2 = $urandom;
        chk({tag, "_busy"}, 64'(BUSY), 64'd1);
        chk({tag, "_o_hold"}, 64'(O), 64'(prev_o));
        if (repulse) begin
            repeat (5) @(posedge clk);
            #2;
            START = 1'b1; M = 32'd7; E = 32'd3; N = 32'd497; R2 = 32'd436;
            @(posedge clk); #2;
            START = 1'b0;
        end
        got = 1'b0;
        for (int c = 0; c < 5000 && !got; c++) begin
            @(posedge clk); #2;
            if (DONE) got = 1'b1;
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        chk({tag, "_o"}, 64'(O), 64'(exp_o));
        chk({tag, "_mm_idle_at_done"}, 64'(mdl_busy), 64'd0);
        @(posedge clk); #2;
        chk({tag, "_done_pulse"}, 64'(DONE), 64'd0);
        chk({tag, "_busy_clr"}, 64'(BUSY), 64'd0);
        chk({tag, "_jobs"}, 64'(mm_jobs - base_jobs), 64'(exp_jobs));
        chk({tag, "_stable"}, 64'(stab_viol - base_viol), 64'd0);
    endtask

    initial begin
        int  base;
        bit  seen_done, seen_busy;
        rst = 1'b1; START = 1'b0; M = '0; E = '0; N = '0; R2 = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_o", 64'(O), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_mm_start", 64'(mm_if.MM_START), 64'd0);
        chk("rst_mm_x", 64'(mm_if.MM_X), 64'd0);
        rst = 1'b0;
        @(posedge clk); #2;

        run_op("e13", 32'd4, 32'd13, 32'd445, 38, 32'd0, 1'b0);
        run_op("e0", 32'd5, 32'd0, 32'd1, 35, 32'd445, 1'b0);
        run_op("e1", 32'd5, 32'd1, 32'd5, 36, 32'd1, 1'b0);
        run_op("restart_busy", 32'd4, 32'd13, 32'd445, 38, 32'd5, 1'b1);

        // Spurious MM_DONE while idle
        base = mm_jobs; seen_done = 1'b0; seen_busy = 1'b0;
        repeat (2) @(posedge clk);
        #2; spur = 1'b1;
        @(posedge clk); #2; spur = 1'b0;
        repeat (5) begin
            @(posedge clk); #2;
            if (DONE) seen_done = 1'b1;
            if (BUSY) seen_busy = 1'b1;
        end
        chk("spur_done", 64'(seen_done), 64'd0);
        chk("spur_busy", 64'(seen_busy), 64'd0);
        chk("spur_jobs", 64'(mm_jobs - base), 64'd0);
        chk("spur_o", 64'(O), 64'd445);

        // Reset during the first SQUARE wait
        base = mm_jobs;
        START = 1'b1; M = 32'd4; E = 32'd13; N = 32'd497; R2 = 32'd436;
        @(posedge clk); #2; START = 1'b0;
        for (int c = 0; c < 300 && (mm_jobs - base) < 3; c++) begin
            @(posedge clk); #2;
        end
        chk("mid_third_job", 64'(mm_jobs - base), 64'd3);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("midrst_o", 64'(O), 64'd0);
        chk("midrst_done", 64'(DONE), 64'd0);
        chk("midrst_busy", 64'(BUSY), 64'd0);
        chk("midrst_mm_start", 64'(mm_if.MM_START), 64'd0);
        chk("midrst_mm_x", 64'(mm_if.MM_X), 64'd0);
        chk("midrst_mm_y", 64'(mm_if.MM_Y), 64'd0);
        chk("midrst_mm_n", 64'(mm_if.MM_N), 64'd0);
        seen_done = 1'b0; seen_busy = 1'b0;
        repeat (10) begin
            @(posedge clk); #2;
            if (DONE) seen_done = 1'b1;
            if (BUSY) seen_busy = 1'b1;
        end
        chk("late_mmdone_done", 64'(seen_done), 64'd0);
        chk("late_mmdone_busy", 64'(seen_busy), 64'd0);
        chk("late_mmdone_jobs", 64'(mm_jobs - base), 64'd3);
        run_op("after_rst", 32'd4, 32'd13, 32'd445, 38, 32'd0, 1'b0);

        // Back-to-back: START in the cycle right after DONE
        run_op("b2b", 32'd2, 32'd10, 32'd30, 37, 32'd445, 1'b0);

        lat_rand = 1'b1;
        run_op("rand_e13", 32'd4, 32'd13, 32'd445, 38, 32'd30, 1'b0);
        run_op("rand_e10", 32'd2, 32'd10, 32'd30, 37, 32'd445, 1'b0);
        run_op("rand_e0", 32'd5, 32'd0, 32'd1, 35, 32'd30, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_modexp_ctrl.md
Name: rsa_modexp_ctrl

Overview:
- Initiator for the Montgomery multiplier's START/DONE interface. Computes O = M^E mod N by left-to-right square-and-multiply in the Montgomery domain.
- Issues one multiplier job at a time, holds its operands, consumes its DONE pulse, and sequences the whole exponentiation.
- Sits between the RSA top-level (host side) and the Montgomery multiplier instance (MM side).

Parameters:
- MAX_BIT, 2048, operand/modulus width; R = 2^MAX_BIT. Small-sim value: 32.
- MAX_BIT_BIT, 12, exponent bit-index counter width; must satisfy 2^MAX_BIT_BIT > MAX_BIT. Use 6 when MAX_BIT = 32.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- START  in  1  host request, sampled only in IDLE
- M  in  MAX_BIT  base; requires M < N
- E  in  MAX_BIT  exponent
- N  in  MAX_BIT  modulus; odd, N > 1
- R2  in  MAX_BIT  R^2 mod N, precomputed by host
- O  out  MAX_BIT  result, valid from the DONE cycle until the next accepted START
- DONE  out  1  one-cycle completion pulse
- BUSY  out  1  high from START acceptance through the DONE cycle
- MM_START  out  1  one-cycle job request to the multiplier
- MM_X  out  MAX_BIT  multiplier X operand
- MM_Y  out  MAX_BIT  multiplier Y operand
- MM_N  out  MAX_BIT  multiplier modulus
- MM_O  in  MAX_BIT  multiplier result, valid in the MM_DONE cycle
- MM_DONE  in  1  multiplier completion pulse

Behaviour:
- Reset values:
  - O = 0; DONE = BUSY = MM_START = 0; MM_X = MM_Y = MM_N = 0.
  - Internal registers: Mbar = Abar = 0, bit index = 0, state IDLE, job-pending flag clear.
- Reset mid-operation: return to IDLE next cycle. Any in-flight MM_DONE is dropped because the pending flag clears.
- Accepted START: latch M, E, N, R2 into internal registers. Host ports are don't-care afterwards.
- MM job issue:
  - Drive MM_X, MM_Y, MM_N and pulse MM_START for exactly one cycle.
  - Operands must stay stable from the MM_START cycle until the cycle after MM_DONE, because the multiplier reads Y and N live during computation.
  - Only one job is outstanding at a time. Wait for MM_DONE, then capture MM_O.
- MM_DONE while no job is pending: ignored.
- States (each MM state = issue cycle + wait):
  - IDLE: START=1 -> TOMONT_M; otherwise stay.
  - TOMONT_M: job (M, R2) -> Mbar.
  - TOMONT_1: job (1, R2) -> Abar = R mod N; set idx = MAX_BIT-1.
  - SQUARE: job (Abar, Abar) -> Abar. If E[idx] -> MULT; otherwise -> NEXT.
  - MULT: job (Abar, Mbar) -> Abar; then -> NEXT.
  - NEXT: if idx == 0 -> FROMMONT; otherwise idx--, -> SQUARE.
  - FROMMONT: job (Abar, 1); O <= MM_O; -> FINISH.
  - FINISH: DONE = 1 for one cycle; -> IDLE.
- All MAX_BIT exponent bits are processed; leading zeros are not skipped. Job count = MAX_BIT + popcount(E) + 3.
- E = 0: no MULT jobs; O = 1.
- START while BUSY: ignored, no queueing.
- START in the FINISH cycle: ignored. START is accepted from the cycle after DONE.
- No reduction is performed on MM_O. The multiplier's conditional subtract is trusted.

Decomposition:
- Shared package rsa_pkg holds:
  - MAX_BIT and MAX_BIT_BIT
  - state encoding constants
  - the MM-job operand-select enum (M_R2, ONE_R2, SQR, MUL, FROM)
- Natural sub-module: mm_job_port. It owns the issue/pending/capture handshake, the operand hold registers and the MM_START pulse, and presents start_job/job_done to the sequencer FSM.

Test Plan:
- MAX_BIT = 32, N = 497, R2 = 436, M = 4, E = 13:
  - O = 445 with a single DONE pulse.
  - Exactly 38 MM_START pulses.
  - Bench multiplier model asserts MM_X/MM_Y/MM_N are stable across every job.
- Same N and R2, M = 5, E = 0 -> O = 1; 35 jobs. Repeat with E = 1 -> O = 5; 36 jobs.
- START re-pulsed while BUSY with different M: ignored; O = 445 still. Spurious MM_DONE injected in IDLE: no state change, no DONE.
- rst asserted during the SQUARE wait for 1 cycle:
  - Next cycle all outputs are at reset values.
  - The late MM_DONE is ignored.
  - A fresh START (M = 4, E = 13) yields O = 445.
- Back-to-back operations: START in the cycle after DONE is accepted. M = 2, E = 10, N = 497, R2 = 436 -> O = 30. O holds 445 until then.
- Multiplier model with variable latency (1 to 40 cycles random per job): results are unchanged, and DONE never precedes the last MM_DONE.
